blit_mem_arbiter: RTL and testbench
===================================

# blit_mem_arbiter

Shares the single memory-controller port between three requesters: the blitter write FIFO drain (write-only), the blitter source reader (read-only) and the CPU data path (read/write). It arbitrates round-robin with write-FIFO-full priority, forwards one transaction at a time with a registered request, and returns in-order read data to the correct requester through a small ordering queue. It sits between the blit datapath/CPU and the SDRAM controller.

## Interface
- `MAX_OUTSTANDING`, 8: maximum reads accepted by memory but not yet returned; power of two, 2..16.
- `BURST_LEN`, 4: maximum consecutive write-port grants in burst mode (see Configuration).
- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low; block in reset while `reset`==0.
- `wr_req` in 1, `wr_addr` in 26, `wr_data` in 32, `wr_be` in 4: blit write FIFO head.
- `wr_ack` out 1: pops the write FIFO.
- `wr_fifo_full` in 1: write FIFO near-full indication.
- `rd_req` in 1, `rd_addr` in 26: blit source read request.
- `rd_ack` out 1, `rd_rvalid` out 1, `rd_rdata` out 32: accept pulse and returned data.
- `cpu_req` in 1, `cpu_write` in 1, `cpu_addr` in 26, `cpu_wdata` in 32, `cpu_be` in 4: CPU request.
- `cpu_ack` out 1, `cpu_rvalid` out 1, `cpu_rdata` out 32.
- `mem_req` out 1, `mem_write` out 1, `mem_addr` out 26, `mem_wdata` out 32, `mem_be` out 4: to memory controller.
- `mem_ack` in 1, `mem_rvalid` in 1, `mem_rdata` in 32: from memory controller.
- `err_rdata` out 1: sticky, set on `mem_rvalid` with no read outstanding.

## Operation
- Requester handshake: `*_req` is a level; payload stable while req high; `*_ack` is a one-cycle pulse consuming exactly one transaction. Requester may change payload the cycle after ack.
- States: IDLE, BUSY. IDLE: select eligible requester, register payload onto `mem_*`, assert `mem_req`, latch grant, go BUSY. BUSY: hold `mem_*` stable until `mem_ack`; then drop `mem_req` next cycle, return to IDLE.
- Eligibility: write port if `wr_req`; read port if `rd_req` and ordering queue not full; CPU if `cpu_req` and (`cpu_write` or queue not full).
- Priority: `wr_fifo_full` high and `wr_req` high → write port wins unconditionally. Otherwise round-robin order wr→rd→cpu starting after last granted port.
- `mem_write`=1 for write port, 0 for read port, `cpu_write` for CPU. Read port drives `mem_be`=4'hF, `mem_wdata`=0.
- Ordering queue: on `mem_ack` of a read, push port id (rd=0, cpu=1). On `mem_rvalid`, pop; route `mem_rdata` to `rd_rdata`/`cpu_rdata` with matching `*_rvalid` pulse. Push and pop in same cycle allowed; count unchanged.
- `mem_rvalid` with queue empty: dropped, `err_rdata` set; cleared only by reset.
- Outstanding count width `$clog2(MAX_OUTSTANDING)+1`; never wraps: full blocks read eligibility.

## Timing
- Reset values: `mem_req`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, all `*_ack`=0, all `*_rvalid`=0, `*_rdata`=0, `err_rdata`=0; state IDLE, queue empty, round-robin pointer = write port.
- Req sampled in IDLE at cycle N → `mem_req` high at N+1.
- `*_ack` is combinational: `mem_ack` & grant, same cycle as `mem_ack`.
- `mem_rvalid` → `*_rvalid`/`*_rdata` registered, one cycle later.
- Back-to-back throughput: one transaction per 2 cycles minimum (ack cycle, IDLE cycle).
- `mem_rvalid` for a read arrives no earlier than the cycle after its `mem_ack` (memory-side guarantee).
- Reset mid-transaction: `mem_req` low the cycle after `reset` sampled low; queue flushed; in-flight `mem_ack`/`mem_rvalid` during reset ignored, no ack or rvalid pulses produced.

## Configuration
- `BLIT_ARB_BURST_EN` defined: after a write-port grant, write port keeps priority over round-robin for up to `BURST_LEN` consecutive transactions while `wr_req` stays high; burst counter resets when another port is granted or `wr_req` low in IDLE. `wr_fifo_full` priority unchanged.
- Not defined: pure round-robin plus full-priority; burst counter absent.

## Structure
- Shared package `blit_pkg`: port-id enum (`PORT_WR`, `PORT_RD`, `PORT_CPU`), arbiter state enum, `ADDR_W`=26, `DATA_W`=32, `BE_W`=4.
- Sub-module `blit_arb_order_fifo`: depth `MAX_OUTSTANDING`, 1-bit entries, push/pop/full/empty/count.

## Test plan
- Single write: `wr_req`=1, addr 26'h0000100, data 32'hDEADBEEF, be 4'hF; `mem_ack` at 3rd BUSY cycle → `mem_*` carry payload from N+1, `wr_ack` one pulse coincident with `mem_ack`, `mem_req` low next cycle.
- All three requesting continuously, `mem_ack` immediate → grant order wr, rd, cpu, wr, rd, cpu.
- Round-robin with `wr_fifo_full`=1 → write port granted every IDLE until `wr_fifo_full`=0.
- 8 reads accepted without `mem_rvalid` → 9th read not issued; one `mem_rvalid` 32'h12345678 → routed to correct port, next read issues.
- Interleaved rd/cpu reads, returns 32'hA, 32'hB → `rd_rvalid` with 32'hA then `cpu_rvalid` with 32'hB; spurious `mem_rvalid` with empty queue → `err_rdata`=1.
- `reset`=0 during BUSY → next cycle all outputs at reset values; with `BLIT_ARB_BURST_EN`, wr+rd requesting → 4 writes then 1 read.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared widths, port identifiers and arbiter state encoding for the blitter
// memory arbiter slice.
package blit_pkg;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        PORT_WR  = 2'd0,
        PORT_RD  = 2'd1,
        PORT_CPU = 2'd2
    } port_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Round-robin successor in the fixed order wr -> rd -> cpu -> wr.
    function automatic port_e port_next(input port_e p);
        case (p)
            PORT_WR: return PORT_RD;
            PORT_RD: return PORT_CPU;
            default: return PORT_WR;
        endcase
    endfunction
endpackage

// File: rtl/blit_mem_arbiter_if.sv
// Memory-controller port bundle: request/payload towards the SDRAM controller,
// accept and read-return back from it.
interface blit_mem_arbiter_if;
    import blit_pkg::*;

    logic              mem_req;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_write, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_write, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/blit_arb_order_fifo.sv
// Ordering queue of 1-bit requester ids for reads accepted by memory but not
// yet returned (0 = blit read port, 1 = CPU). DEPTH must be a power of two.
module blit_arb_order_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     push_id,
    input  logic                     pop,
    output logic                     head_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] slot_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head_id = slot_reg[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            slot_reg[wr_ptr_reg] <= push_id;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/blit_mem_arbiter.sv
// Shares the SDRAM controller port between the blit write drain, blit source
// reader and CPU. Define BLIT_ARB_BURST_EN for write-burst priority.
module blit_mem_arbiter
    import blit_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int BURST_LEN       = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [BE_W-1:0]     wr_be,
    output logic                wr_ack,
    input  logic                wr_fifo_full,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_ack,
    output logic                rd_rvalid,
    output logic [DATA_W-1:0]   rd_rdata,
    input  logic                cpu_req,
    input  logic                cpu_write,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [BE_W-1:0]     cpu_be,
    output logic                cpu_ack,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,
    blit_mem_arbiter_if.master  mem,
    output logic                err_rdata
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e        state_reg, state_next;
    port_e             grant_reg, grant_next;
    port_e             rr_reg, rr_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_write_reg, mem_write_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [BE_W-1:0]   mem_be_reg, mem_be_next;

    logic              rd_rvalid_reg, cpu_rvalid_reg, err_reg;
    logic [DATA_W-1:0] rd_rdata_reg, cpu_rdata_reg;

    logic              q_push, q_pop, q_head, q_full, q_empty;
    logic [CNT_W-1:0]  q_count;
    logic              read_room, busy_ack, burst_hold, sel_valid;
    logic [2:0]        elig;
    port_e             sel_port, cand1, cand2;

    // Bit position matches the port_e encoding: [0]=wr, [1]=rd, [2]=cpu.
    assign read_room = (q_count < CNT_W'(MAX_OUTSTANDING));
    assign elig      = {cpu_req && (cpu_write || read_room), rd_req && read_room, wr_req};
    assign sel_valid = |elig;

    // Accepts seen while reset is asserted must not pop requester FIFOs.
    assign busy_ack = reset && (state_reg == ST_BUSY) && mem.mem_ack;
    assign wr_ack   = busy_ack && (grant_reg == PORT_WR);
    assign rd_ack   = busy_ack && (grant_reg == PORT_RD);
    assign cpu_ack  = busy_ack && (grant_reg == PORT_CPU);

    assign q_push = busy_ack && !mem_write_reg && !q_full;
    assign q_pop  = mem.mem_rvalid && !q_empty;

    blit_arb_order_fifo #(.DEPTH(MAX_OUTSTANDING)) u_order_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (q_push),
        .push_id (grant_reg == PORT_CPU),
        .pop     (q_pop),
        .head_id (q_head),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

`ifdef BLIT_ARB_BURST_EN
    localparam int BCNT_W = $clog2(BURST_LEN + 1);

    logic [BCNT_W-1:0] burst_cnt_reg, burst_cnt_next;

    assign burst_hold = wr_req && (burst_cnt_reg != '0)
                        && (burst_cnt_reg < BCNT_W'(BURST_LEN));

    // Counts consecutive write grants; saturates so an expired burst stays expired.
    always_comb begin
        burst_cnt_next = burst_cnt_reg;
        if (state_reg == ST_IDLE) begin
            if (!wr_req) begin
                burst_cnt_next = '0;
            end else if (sel_valid) begin
                if (sel_port != PORT_WR) begin
                    burst_cnt_next = '0;
                end else if (burst_cnt_reg < BCNT_W'(BURST_LEN)) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            burst_cnt_reg <= '0;
        end else begin
            burst_cnt_reg <= burst_cnt_next;
        end
    end
`else
    assign burst_hold = 1'b0;
`endif

    always_comb begin
        cand1    = port_next(rr_reg);
        cand2    = port_next(cand1);
        sel_port = rr_reg;
        if (wr_req && (wr_fifo_full || burst_hold)) begin
            sel_port = PORT_WR;
        end else if (elig[rr_reg]) begin
            sel_port = rr_reg;
        end else if (elig[cand1]) begin
            sel_port = cand1;
        end else begin
            sel_port = cand2;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        rr_next        = rr_reg;
        mem_req_next   = mem_req_reg;
        mem_write_next = mem_write_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_be_next    = mem_be_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_next   = ST_BUSY;
                    grant_next   = sel_port;
                    rr_next      = port_next(sel_port);
                    mem_req_next = 1'b1;
                    case (sel_port)
                        PORT_WR: begin
                            mem_write_next = 1'b1;
                            mem_addr_next  = wr_addr;
                            mem_wdata_next = wr_data;
                            mem_be_next    = wr_be;
                        end
                        PORT_RD: begin
                            mem_write_next = 1'b0;
                            mem_addr_next  = rd_addr;
                            mem_wdata_next = '0;
                            mem_be_next    = '1;
                        end
                        default: begin
                            mem_write_next = cpu_write;
                            mem_addr_next  = cpu_addr;
                            mem_wdata_next = cpu_wdata;
                            mem_be_next    = cpu_be;
                        end
                    endcase
                end
            end
            default: begin
                if (mem.mem_ack) begin
                    state_next   = ST_IDLE;
                    mem_req_next = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= PORT_WR;
            rr_reg        <= PORT_WR;
            mem_req_reg   <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            rr_reg        <= rr_next;
            mem_req_reg   <= mem_req_next;
            mem_write_reg <= mem_write_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_be_reg    <= mem_be_next;
        end
    end

    // Read return routing by the queue head; a return with nothing queued is an error.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_rvalid_reg  <= 1'b0;
            cpu_rvalid_reg <= 1'b0;
            rd_rdata_reg   <= '0;
            cpu_rdata_reg  <= '0;
            err_reg        <= 1'b0;
        end else begin
            rd_rvalid_reg  <= 1'b0;
            cpu_rvalid_reg <= 1'b0;
            if (mem.mem_rvalid) begin
                if (q_empty) begin
                    err_reg <= 1'b1;
                end else if (q_head) begin
                    cpu_rvalid_reg <= 1'b1;
                    cpu_rdata_reg  <= mem.mem_rdata;
                end else begin
                    rd_rvalid_reg <= 1'b1;
                    rd_rdata_reg  <= mem.mem_rdata;
                end
            end
        end
    end

    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_write = mem_write_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;
    assign mem.mem_be    = mem_be_reg;
    assign rd_rvalid     = rd_rvalid_reg;
    assign rd_rdata      = rd_rdata_reg;
    assign cpu_rvalid    = cpu_rvalid_reg;
    assign cpu_rdata     = cpu_rdata_reg;
    assign err_rdata     = err_reg;
endmodule

// File: tb/tb_blit_mem_arbiter.sv
// Directed bench for blit_mem_arbiter; burst expectations follow BLIT_ARB_BURST_EN.
module tb_blit_mem_arbiter;
    import blit_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              wr_req, wr_fifo_full, wr_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              rd_req, rd_ack, rd_rvalid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_rdata;
    logic              cpu_req, cpu_write, cpu_ack, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic [BE_W-1:0]   cpu_be;
    logic              err_rdata;

    int tests = 0;
    int fails = 0;

    // Ack vectors are {wr, rd, cpu}.
    logic [2:0] exp_rr [6] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
`ifdef BLIT_ARB_BURST_EN
    logic [2:0] exp_bu [5] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010};
`else
    logic [2:0] exp_bu [5] = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100};
`endif

    blit_mem_arbiter_if mem_bus();

    blit_mem_arbiter #(.MAX_OUTSTANDING(8), .BURST_LEN(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_be        (wr_be),
        .wr_ack       (wr_ack),
        .wr_fifo_full (wr_fifo_full),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_ack       (rd_ack),
        .rd_rvalid    (rd_rvalid),
        .rd_rdata     (rd_rdata),
        .cpu_req      (cpu_req),
        .cpu_write    (cpu_write),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_be       (cpu_be),
        .cpu_ack      (cpu_ack),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .mem          (mem_bus),
        .err_rdata    (err_rdata)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ackv();
        return {wr_ack, rd_ack, cpu_ack};
    endfunction

    task automatic clear_inputs();
        wr_req = 1'b0; wr_fifo_full = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_req = 1'b0; rd_addr = '0;
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        clear_inputs();
        tick(); tick(); settle();
        check("rst_mem_req",    32'(mem_bus.mem_req),   32'h0);
        check("rst_mem_write",  32'(mem_bus.mem_write), 32'h0);
        check("rst_mem_addr",   32'(mem_bus.mem_addr),  32'h0);
        check("rst_mem_wdata",  32'(mem_bus.mem_wdata), 32'h0);
        check("rst_mem_be",     32'(mem_bus.mem_be),    32'h0);
        check("rst_acks",       32'(ackv()),            32'h0);
        check("rst_rd_rvalid",  32'(rd_rvalid),         32'h0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid),        32'h0);
        check("rst_rd_rdata",   32'(rd_rdata),          32'h0);
        check("rst_cpu_rdata",  32'(cpu_rdata),         32'h0);
        check("rst_err",        32'(err_rdata),         32'h0);
        reset = 1'b1;

        // Single write, memory accepts on the third BUSY cycle.
        tick();
        wr_req = 1'b1; wr_addr = 26'h0000100; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        settle();
        check("t1_req_cycle_n", 32'(mem_bus.mem_req), 32'h0);
        tick(); settle();
        check("t1_mem_req",   32'(mem_bus.mem_req),   32'h1);
        check("t1_mem_write", 32'(mem_bus.mem_write), 32'h1);
        check("t1_mem_addr",  32'(mem_bus.mem_addr),  32'h100);
        check("t1_mem_wdata", 32'(mem_bus.mem_wdata), 32'hDEADBEEF);
        check("t1_mem_be",    32'(mem_bus.mem_be),    32'hF);
        check("t1_no_ack_b1", 32'(wr_ack),            32'h0);
        tick(); settle();
        check("t1_hold_b2",   32'(mem_bus.mem_req),   32'h1);
        check("t1_addr_b2",   32'(mem_bus.mem_addr),  32'h100);
        tick(); mem_bus.mem_ack = 1'b1; settle();
        check("t1_wr_ack",    32'(wr_ack),            32'h1);
        check("t1_req_b3",    32'(mem_bus.mem_req),   32'h1);
        $display("[TB] t1 write addr=%0h data=%0h acked", mem_bus.mem_addr, mem_bus.mem_wdata);
        tick(); mem_bus.mem_ack = 1'b0; wr_req = 1'b0; settle();
        check("t1_req_drop",  32'(mem_bus.mem_req),   32'h0);
        check("t1_ack_once",  32'(wr_ack),            32'h0);

        // All three requesting, memory accepts immediately.
        do_reset();
        tick();
        wr_req = 1'b1; wr_addr = 26'h0000200; wr_data = 32'h1; wr_be = 4'hF;
        rd_req = 1'b1; rd_addr = 26'h0000300;
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 26'h0000400; cpu_wdata = 32'h2; cpu_be = 4'h3;
        mem_bus.mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); settle();
            $display("[TB] t2 grant %0d acks=%b", i, ackv());
            check($sformatf("t2_grant%0d", i), 32'(ackv()), 32'(exp_rr[i]));
            if (i == 1) begin
                check("t2_rd_write", 32'(mem_bus.mem_write), 32'h0);
                check("t2_rd_be",    32'(mem_bus.mem_be),    32'hF);
                check("t2_rd_wdata", 32'(mem_bus.mem_wdata), 32'h0);
                check("t2_rd_addr",  32'(mem_bus.mem_addr),  32'h300);
            end
            tick(); settle();
            check($sformatf("t2_idle%0d", i), 32'(ackv()), 32'h0);
        end

        // Write FIFO full overrides round-robin.
        do_reset();
        tick();
        wr_req = 1'b1; rd_req = 1'b1; cpu_req = 1'b1; cpu_write = 1'b1;
        wr_fifo_full = 1'b1; mem_bus.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            $display("[TB] t3 grant %0d acks=%b", i, ackv());
            check($sformatf("t3_full_grant%0d", i), 32'(ackv()), 32'h4);
            tick();
            if (i == 2) wr_fifo_full = 1'b0;
        end
        tick(); settle();
        check("t3_after_full_rd", 32'(ackv()), 32'h2);
        tick(); tick(); settle();
        check("t3_after_full_cpu", 32'(ackv()), 32'h1);

        // Eight reads outstanding block the ninth until one returns.
        do_reset();
        tick();
        rd_req = 1'b1; rd_addr = 26'h0000500; mem_bus.mem_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(); settle();
            $display("[TB] t4 read %0d acks=%b", i, ackv());
            check($sformatf("t4_read%0d", i), 32'(rd_ack), 32'h1);
            tick();
        end
        tick(); settle();
        check("t4_ninth_req",   32'(mem_bus.mem_req), 32'h0);
        check("t4_ninth_ack",   32'(rd_ack),          32'h0);
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h12345678;
        tick(); mem_bus.mem_rvalid = 1'b0; settle();
        check("t4_rd_rvalid",   32'(rd_rvalid),       32'h1);
        check("t4_rd_rdata",    32'(rd_rdata),        32'h12345678);
        check("t4_cpu_rvalid",  32'(cpu_rvalid),      32'h0);
        check("t4_still_block", 32'(mem_bus.mem_req), 32'h0);
        tick(); settle();
        check("t4_ninth_issue", 32'(mem_bus.mem_req), 32'h1);
        check("t4_ninth_rdack", 32'(rd_ack),          32'h1);
        rd_req = 1'b0;
        tick(); settle();
        check("t4_rvalid_pulse", 32'(rd_rvalid),      32'h0);

        // Interleaved rd/cpu reads return in order; then a spurious return.
        do_reset();
        tick();
        rd_req = 1'b1; rd_addr = 26'h0000600;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 26'h0000700;
        mem_bus.mem_ack = 1'b1;
        tick(); settle();
        check("t5_rd_first", 32'(ackv()), 32'h2);
        tick(); rd_req = 1'b0; settle();
        tick(); settle();
        check("t5_cpu_second", 32'(ackv()), 32'h1);
        check("t5_cpu_read",   32'(mem_bus.mem_write), 32'h0);
        tick();
        cpu_req = 1'b0; mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hA;
        settle();
        tick(); mem_bus.mem_rdata = 32'hB; settle();
        $display("[TB] t5 return rd_rvalid=%b rd_rdata=%0h", rd_rvalid, rd_rdata);
        check("t5_rd_rvalid",  32'(rd_rvalid),  32'h1);
        check("t5_rd_rdata",   32'(rd_rdata),   32'hA);
        check("t5_cpu_idle",   32'(cpu_rvalid), 32'h0);
        tick(); mem_bus.mem_rvalid = 1'b0; settle();
        $display("[TB] t5 return cpu_rvalid=%b cpu_rdata=%0h", cpu_rvalid, cpu_rdata);
        check("t5_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        check("t5_cpu_rdata",  32'(cpu_rdata),  32'hB);
        check("t5_rd_idle",    32'(rd_rvalid),  32'h0);
        check("t5_err_clean",  32'(err_rdata),  32'h0);
        tick(); mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hC; settle();
        tick(); mem_bus.mem_rvalid = 1'b0; settle();
        check("t5_err_set",      32'(err_rdata),  32'h1);
        check("t5_spur_rd",      32'(rd_rvalid),  32'h0);
        check("t5_spur_cpu",     32'(cpu_rvalid), 32'h0);
        tick(); settle();
        check("t5_err_sticky",   32'(err_rdata),  32'h1);

        // Reset while BUSY, with memory activity during reset.
        tick();
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 26'h0ABCDEF;
        cpu_wdata = 32'hCAFE0001; cpu_be = 4'h3;
        settle();
        tick(); settle();
        check("t6_busy_req",   32'(mem_bus.mem_req),   32'h1);
        check("t6_busy_addr",  32'(mem_bus.mem_addr),  32'h0ABCDEF);
        check("t6_busy_be",    32'(mem_bus.mem_be),    32'h3);
        check("t6_busy_write", 32'(mem_bus.mem_write), 32'h1);
        tick();
        reset = 1'b0; mem_bus.mem_ack = 1'b1; mem_bus.mem_rvalid = 1'b1;
        settle();
        check("t6_ack_in_rst", 32'(cpu_ack), 32'h0);
        tick(); settle();
        check("t6_req",        32'(mem_bus.mem_req),   32'h0);
        check("t6_write",      32'(mem_bus.mem_write), 32'h0);
        check("t6_addr",       32'(mem_bus.mem_addr),  32'h0);
        check("t6_wdata",      32'(mem_bus.mem_wdata), 32'h0);
        check("t6_be",         32'(mem_bus.mem_be),    32'h0);
        check("t6_acks",       32'(ackv()),            32'h0);
        check("t6_err",        32'(err_rdata),         32'h0);
        check("t6_rd_rvalid",  32'(rd_rvalid),         32'h0);
        check("t6_cpu_rvalid", 32'(cpu_rvalid),        32'h0);
        check("t6_rd_rdata",   32'(rd_rdata),          32'h0);

        // Write and read both requesting: burst mode favours writes.
        do_reset();
        tick();
        wr_req = 1'b1; wr_addr = 26'h0000800; wr_data = 32'h5; wr_be = 4'hF;
        rd_req = 1'b1; rd_addr = 26'h0000900; mem_bus.mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            $display("[TB] t7 grant %0d acks=%b", i, ackv());
            check($sformatf("t7_grant%0d", i), 32'(ackv()), 32'(exp_bu[i]));
            tick();
        end

        clear_inputs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
